// File: rtl/pic_pkg.sv
// Shared types and helpers for the clocked PIC priority resolver.
// Holds the ack FSM states, rotate commands and rotating-priority math.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_e;

  localparam logic [1:0] ROT_FIXED    = 2'b00;
  localparam logic [1:0] ROT_ON_EOI   = 2'b01;
  localparam logic [1:0] ROT_SPECIFIC = 2'b10;

  localparam int MAX_IRQ = 32;

  // Rank of channel idx when low is the lowest-priority channel.
  function automatic int rank_of(int idx, int low, int n);
    int r;
    r = idx - low - 1;
    if (r < 0) r = r + n;
    return r;
  endfunction

  // Channel of the highest-ranked set bit of v, or -1 if v is empty.
  function automatic int first_ranked(logic [MAX_IRQ-1:0] v,
                                      int low, int n);
    int pick;
    int ch;
    pick = -1;
    for (int k = MAX_IRQ - 1; k >= 0; k--) begin
      if (k < n) begin
        ch = low + 1 + k;
        if (ch >= n) ch = ch - n;
        if (v[ch[4:0]]) pick = ch;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rotating_priority_select.sv
// Picks the highest-ranked set bit of a request vector
// under a rotating lowest-priority channel.
module rotating_priority_select
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int LEVEL_W = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_vec,
  input  logic [LEVEL_W-1:0] i_lowest,
  output logic               o_found,
  output logic [LEVEL_W-1:0] o_index,
  output logic [NUM_IRQ-1:0] o_onehot
);

  int w_pick;

  // Scan ranks from highest to lowest and report the winner.
  always_comb begin
    w_pick   = first_ranked(MAX_IRQ'(i_vec), int'(i_lowest), NUM_IRQ);
    o_found  = (w_pick >= 0);
    o_index  = '0;
    o_onehot = '0;
    if (o_found) begin
      o_index           = LEVEL_W'(w_pick);
      o_onehot[o_index] = 1'b1;
    end
  end

endmodule

// File: rtl/priority_resolver_n.sv
// Clocked N-channel 8259-style priority resolver with INTA handshake,
// auto/non-specific EOI, rotation and special-mask mode.
module priority_resolver_n
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int LEVEL_W = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic               auto_eoi,
  input  logic               special_mask,
  input  logic               rot_valid,
  input  logic [1:0]         rot_cmd,
  input  logic [LEVEL_W-1:0] rot_level,
  input  logic               eoi_valid,
  input  logic               INTA,
  output logic               INT,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic [NUM_IRQ-1:0] isr_set,
  output logic [NUM_IRQ-1:0] isr_clear,
  output logic [LEVEL_W-1:0] vector,
  output logic [LEVEL_W-1:0] lowest_level
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_inta_q;
  logic               r_spur;
  logic               r_rot_mode;
  logic               r_int;
  logic [LEVEL_W-1:0] r_lowest;
  logic [LEVEL_W-1:0] r_vector;
  logic [NUM_IRQ-1:0] r_irr_clr;
  logic [NUM_IRQ-1:0] r_isr_set;
  logic [NUM_IRQ-1:0] r_isr_clr;

  logic [NUM_IRQ-1:0] w_cand_vec;
  logic [NUM_IRQ-1:0] w_blk_vec;
  logic               w_cand_found;
  logic [LEVEL_W-1:0] w_cand_idx;
  logic [NUM_IRQ-1:0] w_cand_oh;
  logic               w_blk_found;
  logic [LEVEL_W-1:0] w_blk_idx;
  logic [NUM_IRQ-1:0] w_blk_oh;
  int                 w_cand_rank;
  int                 w_blk_rank;
  logic               w_pending;
  logic               w_fall;
  logic               w_rise;
  logic               w_ack1;
  logic               w_aeoi;
  logic [NUM_IRQ-1:0] w_vec_oh;
  int                 w_eoi_pick;
  logic               w_eoi_found;
  logic [LEVEL_W-1:0] w_eoi_idx;
  logic [NUM_IRQ-1:0] w_eoi_oh;
  logic               w_rot_nxt;
  logic [LEVEL_W-1:0] w_low_nxt;
  logic [NUM_IRQ-1:0] w_isr_clr;

  assign w_cand_vec = irr & ~imr;
  assign w_blk_vec  = special_mask ? (isr & ~imr) : isr;

  rotating_priority_select #(
    .NUM_IRQ (NUM_IRQ),
    .LEVEL_W (LEVEL_W)
  ) u_cand (
    .i_vec    (w_cand_vec),
    .i_lowest (r_lowest),
    .o_found  (w_cand_found),
    .o_index  (w_cand_idx),
    .o_onehot (w_cand_oh)
  );

  rotating_priority_select #(
    .NUM_IRQ (NUM_IRQ),
    .LEVEL_W (LEVEL_W)
  ) u_blk (
    .i_vec    (w_blk_vec),
    .i_lowest (r_lowest),
    .o_found  (w_blk_found),
    .o_index  (w_blk_idx),
    .o_onehot (w_blk_oh)
  );

  // Candidate must strictly outrank the in-service level to preempt.
  always_comb begin
    w_cand_rank = rank_of(int'(w_cand_idx), int'(r_lowest), NUM_IRQ);
    w_blk_rank  = rank_of(int'(w_blk_idx), int'(r_lowest), NUM_IRQ);
    w_pending   = w_cand_found
                  && ((w_cand_oh & w_blk_oh) == '0)
                  && (!w_blk_found || (w_cand_rank < w_blk_rank));
  end

  assign w_fall   = r_inta_q & ~INTA;
  assign w_rise   = ~r_inta_q & INTA;
  assign w_ack1   = (r_state == IDLE) && w_fall;
  assign w_aeoi   = (r_state == ACK1) && w_fall && auto_eoi && !r_spur;
  assign w_vec_oh = NUM_IRQ'(1) << r_vector;

  // Non-specific EOI targets the highest-ranked in-service channel.
  always_comb begin
    w_eoi_pick  = first_ranked(MAX_IRQ'(isr), int'(r_lowest), NUM_IRQ);
    w_eoi_found = (w_eoi_pick >= 0);
    w_eoi_idx   = '0;
    w_eoi_oh    = '0;
    if (w_eoi_found) begin
      w_eoi_idx           = LEVEL_W'(w_eoi_pick);
      w_eoi_oh[w_eoi_idx] = 1'b1;
    end
  end

  // Ack FSM next state: two INTA falls, then wait for INTA high.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_fall) w_state_nxt = ACK1;
      ACK1:    if (w_fall) w_state_nxt = ACK2;
      ACK2:    if (w_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // EOI clears and rotation; a specific rotate overrides EOI rotation.
  always_comb begin
    w_rot_nxt = r_rot_mode;
    w_low_nxt = r_lowest;
    w_isr_clr = '0;
    if (w_aeoi) begin
      w_isr_clr = w_isr_clr | w_vec_oh;
      if (r_rot_mode) w_low_nxt = r_vector;
    end
    if (eoi_valid && w_eoi_found) begin
      w_isr_clr = w_isr_clr | w_eoi_oh;
      if (r_rot_mode) w_low_nxt = w_eoi_idx;
    end
    if (rot_valid) begin
      unique case (rot_cmd)
        ROT_FIXED:    w_rot_nxt = 1'b0;
        ROT_ON_EOI:   w_rot_nxt = 1'b1;
        ROT_SPECIFIC: w_low_nxt = rot_level;
        default:      w_rot_nxt = r_rot_mode;
      endcase
    end
  end

  // INTA history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_inta_q <= 1'b1;
    else       r_inta_q <= INTA;
  end

  // FSM state, INT and priority rotation registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_int      <= 1'b0;
      r_lowest   <= LEVEL_W'(NUM_IRQ - 1);
      r_rot_mode <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_int      <= (r_state == IDLE) && !w_fall && w_pending;
      r_lowest   <= w_low_nxt;
      r_rot_mode <= w_rot_nxt;
    end
  end

  // Acknowledged vector and one-cycle register strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vector  <= '0;
      r_spur    <= 1'b0;
      r_irr_clr <= '0;
      r_isr_set <= '0;
      r_isr_clr <= '0;
    end else begin
      r_irr_clr <= w_ack1 ? w_cand_oh : '0;
      r_isr_set <= w_ack1 ? w_cand_oh : '0;
      r_isr_clr <= w_isr_clr;
      if (w_ack1) begin
        r_vector <= w_cand_found ? w_cand_idx
                                 : LEVEL_W'(NUM_IRQ - 1);
        r_spur   <= !w_cand_found;
      end
    end
  end

  assign INT          = r_int;
  assign irr_clear    = r_irr_clr;
  assign isr_set      = r_isr_set;
  assign isr_clear    = r_isr_clr;
  assign vector       = r_vector;
  assign lowest_level = r_lowest;

endmodule

// File: tb/tb_priority_resolver_n.sv
// Scoreboard bench for priority_resolver_n (8- and 16-channel).
// Expectations are queued with the stimulus and popped at sample time.
module tb_priority_resolver_n;

  logic        clk;
  logic        reset;
  logic [7:0]  irr, imr, isr;
  logic        auto_eoi, special_mask, rot_valid, eoi_valid, INTA;
  logic [1:0]  rot_cmd;
  logic [2:0]  rot_level;
  logic        INT;
  logic [7:0]  irr_clear, isr_set, isr_clear;
  logic [2:0]  vector, lowest_level;

  logic [15:0] irr16, isr16;
  logic        INTA16, INT16;
  logic [15:0] irr_clear16, isr_set16, isr_clear16;
  logic [3:0]  vector16, lowest16;

  logic [31:0] sb_q[$];
  logic [31:0] e;
  int          checks;
  int          errors;

  priority_resolver_n #(.NUM_IRQ(8)) dut (
    .clk(clk), .reset(reset), .irr(irr), .imr(imr), .isr(isr),
    .auto_eoi(auto_eoi), .special_mask(special_mask),
    .rot_valid(rot_valid), .rot_cmd(rot_cmd), .rot_level(rot_level),
    .eoi_valid(eoi_valid), .INTA(INTA), .INT(INT),
    .irr_clear(irr_clear), .isr_set(isr_set), .isr_clear(isr_clear),
    .vector(vector), .lowest_level(lowest_level)
  );

  priority_resolver_n #(.NUM_IRQ(16)) dut16 (
    .clk(clk), .reset(reset), .irr(irr16), .imr(16'h0000),
    .isr(isr16), .auto_eoi(1'b0), .special_mask(1'b0),
    .rot_valid(1'b0), .rot_cmd(2'b00), .rot_level(4'd0),
    .eoi_valid(1'b0), .INTA(INTA16), .INT(INT16),
    .irr_clear(irr_clear16), .isr_set(isr_set16),
    .isr_clear(isr_clear16), .vector(vector16),
    .lowest_level(lowest16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_set(logic [7:0] v);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    sb_q.push_back(32'd0); sb_q.push_back(32'd7);
    sb_q.push_back(32'd15);
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL rst_int: got %0h want %0h", INT, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(irr_clear | isr_set | isr_clear) !== e) begin errors++;
      $display("FAIL rst_strobes: got %0h want %0h",
               irr_clear | isr_set | isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL rst_vector: got %0h want %0h", vector, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL rst_lowest: got %0h want %0h", lowest_level, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest16) !== e) begin errors++;
      $display("FAIL rst_lowest16: got %0h want %0h", lowest16, e); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority();
    irr = 8'h24; sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL fix_int: got %0h want %0h", INT, e); end
    INTA = 1'b0;
    sb_q.push_back(32'h04); sb_q.push_back(32'h04);
    sb_q.push_back(32'd2); sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(isr_set) !== e) begin errors++;
      $display("FAIL fix_isr_set: got %0h want %0h", isr_set, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(irr_clear) !== e) begin errors++;
      $display("FAIL fix_irr_clear: got %0h want %0h", irr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL fix_vector: got %0h want %0h", vector, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL fix_int_drop: got %0h want %0h", INT, e); end
    irr = 8'h20; isr = 8'h04; INTA = 1'b1;
    tick();
    INTA = 1'b0;
    sb_q.push_back(32'd0); sb_q.push_back(32'd2);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL fix_no_aeoi: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL fix_vec_hold: got %0h want %0h", vector, e); end
    INTA = 1'b1;
    tick();
    sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL fix_blocked: got %0h want %0h", INT, e); end
    eoi_valid = 1'b1;
    sb_q.push_back(32'h04); sb_q.push_back(32'd7);
    tick();
    eoi_valid = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL fix_eoi: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL fix_eoi_norot: got %0h want %0h", lowest_level, e); end
    isr = 8'h00; irr = 8'h00;
    tick(); tick();
  endtask

  task automatic test_nesting();
    isr = 8'h08; irr = 8'h10; sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL nest_lower: got %0h want %0h", INT, e); end
    irr = 8'h02; sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL nest_higher: got %0h want %0h", INT, e); end
    irr = 8'h10; isr = 8'h10; sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL nest_equal: got %0h want %0h", INT, e); end
    isr = 8'h08; special_mask = 1'b1; imr = 8'h08;
    sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL nest_smm: got %0h want %0h", INT, e); end
    special_mask = 1'b0; imr = 8'h00; isr = 8'h00; irr = 8'h00;
    tick(); tick();
  endtask

  task automatic test_auto_eoi_rotate();
    rot_valid = 1'b1; rot_cmd = 2'b01; sb_q.push_back(32'd7);
    tick();
    rot_valid = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL aeoi_mode_on: got %0h want %0h", lowest_level, e); end
    auto_eoi = 1'b1; irr = 8'h01;
    tick();
    INTA = 1'b0;
    sb_q.push_back(32'd0); sb_q.push_back(32'h01);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL aeoi_vec0: got %0h want %0h", vector, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(isr_set) !== e) begin errors++;
      $display("FAIL aeoi_set0: got %0h want %0h", isr_set, e); end
    isr = 8'h01; irr = 8'h00; INTA = 1'b1;
    tick();
    INTA = 1'b0;
    sb_q.push_back(32'h01); sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL aeoi_clr0: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL aeoi_rot0: got %0h want %0h", lowest_level, e); end
    isr = 8'h00; INTA = 1'b1;
    tick();
    irr = 8'h81;
    tick();
    INTA = 1'b0;
    sb_q.push_back(32'd7); sb_q.push_back(32'h80);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL aeoi_vec7: got %0h want %0h", vector, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(irr_clear) !== e) begin errors++;
      $display("FAIL aeoi_irrclr7: got %0h want %0h", irr_clear, e); end
    isr = 8'h80; irr = 8'h01; INTA = 1'b1;
    tick();
    INTA = 1'b0;
    sb_q.push_back(32'h80); sb_q.push_back(32'd7);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL aeoi_clr7: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL aeoi_rot7: got %0h want %0h", lowest_level, e); end
    isr = 8'h00; irr = 8'h00; INTA = 1'b1;
    tick();
    auto_eoi = 1'b0; rot_valid = 1'b1; rot_cmd = 2'b00;
    tick();
    rot_valid = 1'b0;
    tick();
  endtask

  task automatic test_specific_rotate();
    rot_valid = 1'b1; rot_cmd = 2'b10; rot_level = 3'd3;
    sb_q.push_back(32'd3);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL spec_rot3: got %0h want %0h", lowest_level, e); end
    rot_cmd = 2'b11; rot_level = 3'd5; sb_q.push_back(32'd3);
    tick();
    rot_valid = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL spec_rot_ign: got %0h want %0h", lowest_level, e); end
    irr = 8'h11;
    tick();
    INTA = 1'b0;
    sb_q.push_back(32'd4); sb_q.push_back(32'h10);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL spec_vec4: got %0h want %0h", vector, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(isr_set) !== e) begin errors++;
      $display("FAIL spec_set4: got %0h want %0h", isr_set, e); end
    isr = 8'h10; irr = 8'h01; INTA = 1'b1;
    tick();
    INTA = 1'b0; tick();
    INTA = 1'b1; tick();
    rot_valid = 1'b1; rot_cmd = 2'b01;
    tick();
    rot_valid = 1'b0; eoi_valid = 1'b1;
    sb_q.push_back(32'h10); sb_q.push_back(32'd4);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL eoi_clr4: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL eoi_rot4: got %0h want %0h", lowest_level, e); end
    rot_valid = 1'b1; rot_cmd = 2'b10; rot_level = 3'd6;
    sb_q.push_back(32'h10); sb_q.push_back(32'd6);
    tick();
    rot_valid = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL eoi_spec_clr: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL eoi_spec_wins: got %0h want %0h", lowest_level, e); end
    isr = 8'h00; irr = 8'h00;
    sb_q.push_back(32'd0); sb_q.push_back(32'd6);
    tick();
    eoi_valid = 1'b0;
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL eoi_empty_clr: got %0h want %0h", isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL eoi_empty_rot: got %0h want %0h", lowest_level, e); end
    rot_valid = 1'b1; rot_cmd = 2'b10; rot_level = 3'd7;
    tick();
    rot_cmd = 2'b00;
    tick();
    rot_valid = 1'b0;
    tick();
  endtask

  task automatic test_spurious();
    irr = 8'h04; sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL spur_int: got %0h want %0h", INT, e); end
    irr = 8'h00; INTA = 1'b0;
    sb_q.push_back(32'd7); sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL spur_vec: got %0h want %0h", vector, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(isr_set | irr_clear) !== e) begin errors++;
      $display("FAIL spur_strobes: got %0h want %0h",
               isr_set | irr_clear, e); end
    auto_eoi = 1'b1; INTA = 1'b1;
    tick();
    INTA = 1'b0; sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(isr_clear) !== e) begin errors++;
      $display("FAIL spur_no_aeoi: got %0h want %0h", isr_clear, e); end
    INTA = 1'b1;
    tick();
    auto_eoi = 1'b0; irr = 8'h02; sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL spur_idle: got %0h want %0h", INT, e); end
    irr = 8'h00;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    rot_valid = 1'b1; rot_cmd = 2'b10; rot_level = 3'd2;
    tick();
    rot_valid = 1'b0; irr = 8'h08;
    tick();
    INTA = 1'b0;
    tick();
    reset = 1'b1;
    sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    sb_q.push_back(32'd7); sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL rmid_int: got %0h want %0h", INT, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(irr_clear | isr_set | isr_clear) !== e) begin errors++;
      $display("FAIL rmid_strobes: got %0h want %0h",
               irr_clear | isr_set | isr_clear, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(lowest_level) !== e) begin errors++;
      $display("FAIL rmid_lowest: got %0h want %0h", lowest_level, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(vector) !== e) begin errors++;
      $display("FAIL rmid_vector: got %0h want %0h", vector, e); end
    INTA = 1'b1; irr = 8'h00;
    tick();
    reset = 1'b0; sb_q.push_back(32'd0);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(irr_clear | isr_set | isr_clear) !== e) begin errors++;
      $display("FAIL rmid_release: got %0h want %0h",
               irr_clear | isr_set | isr_clear, e); end
    irr = 8'h08; sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT) !== e) begin errors++;
      $display("FAIL rmid_idle: got %0h want %0h", INT, e); end
    irr = 8'h00;
    tick(); tick();
  endtask

  task automatic test_n16();
    irr16 = 16'h8000; sb_q.push_back(32'd1);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(INT16) !== e) begin errors++;
      $display("FAIL n16_int: got %0h want %0h", INT16, e); end
    INTA16 = 1'b0;
    sb_q.push_back(32'd15); sb_q.push_back(32'h8000);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(vector16) !== e) begin errors++;
      $display("FAIL n16_vec15: got %0h want %0h", vector16, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(isr_set16) !== e) begin errors++;
      $display("FAIL n16_set15: got %0h want %0h", isr_set16, e); end
    irr16 = 16'h0000; INTA16 = 1'b1; tick();
    INTA16 = 1'b0; tick();
    INTA16 = 1'b1; tick();
    irr16 = 16'h8100;
    tick();
    INTA16 = 1'b0; sb_q.push_back(32'd8);
    tick();
    e = sb_q.pop_front(); checks++;
    if (32'(vector16) !== e) begin errors++;
      $display("FAIL n16_vec8: got %0h want %0h", vector16, e); end
    irr16 = 16'h0000; INTA16 = 1'b1; tick();
    INTA16 = 1'b0; tick();
    INTA16 = 1'b1; tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    int         x;
    for (int n = 0; n < 6; n++) begin
      v = 8'($urandom_range(1, 255));
      x = lowest_set(v);
      irr = v;
      tick();
      INTA = 1'b0;
      sb_q.push_back(32'(x)); sb_q.push_back(32'd1 << x);
      tick();
      e = sb_q.pop_front(); checks++;
      if (32'(vector) !== e) begin errors++;
        $display("FAIL b2b_vec irr=%0h: got %0h want %0h", v, vector, e); end
      e = sb_q.pop_front(); checks++;
      if (32'(isr_set) !== e) begin errors++;
        $display("FAIL b2b_set irr=%0h: got %0h want %0h", v, isr_set, e); end
      INTA = 1'b1; tick();
      INTA = 1'b0; tick();
      INTA = 1'b1; irr = 8'h00; tick();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; INTA = 1'b1; INTA16 = 1'b1;
    irr = '0; imr = '0; isr = '0; irr16 = '0; isr16 = '0;
    auto_eoi = 1'b0; special_mask = 1'b0; rot_valid = 1'b0;
    rot_cmd = 2'b00; rot_level = 3'd0; eoi_valid = 1'b0;
    test_reset();
    test_fixed_priority();
    test_nesting();
    test_auto_eoi_rotate();
    test_specific_rotate();
    test_spurious();
    test_reset_mid();
    test_n16();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
